// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-enable data memory with load/store alignment, fault reporting, registered valid/ready response and post-reset clear
module dmem_lsu #(
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic             r_busy, r_valid, r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    w_idx;
  logic             w_oor, w_fault, w_acc, w_st, w_clr;
  logic [3:0]       w_be;
  logic [31:0]      w_wd, w_word, w_ld;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  assign w_idx     = req_addr[AW+1:2];
  assign w_oor     = (req_addr >> (AW + 2)) != '0;
  assign w_fault   = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) || w_oor;
  assign req_ready = !rst && r_state == S_RUN && (!r_valid || resp_ready);
  assign w_acc     = req_valid && req_ready;
  assign w_st      = w_acc && req_we && !w_fault;
  assign w_clr     = !rst && r_state == S_CLEAR;
  assign w_be      = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                     req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd      = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                     req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign w_word    = r_mem[w_idx];
  assign w_byte    = 8'(w_word >> {req_addr[1:0], 3'b000});
  assign w_half    = req_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_ld      = req_size == 2'b00 ? {{24{w_byte[7] && !req_unsigned}}, w_byte} :
                     req_size == 2'b01 ? {{16{w_half[15] && !req_unsigned}}, w_half} : w_word;
  always_ff @(posedge clk)
    if (w_clr) r_mem[r_idx] <= '0;
    else if (w_st)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_RUN;
      r_busy  <= CLEAR_ON_RESET != 0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_idx <= r_idx + 1'b1;
        if (r_idx == AW'(DEPTH - 1)) begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
      end
      if (w_acc) begin
        r_valid <= 1'b1;
        r_rdata <= (req_we || w_fault) ? 32'h0 : w_ld;
        r_err   <= w_fault;
      end else if (resp_ready) r_valid <= 1'b0;
    end
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign busy       = r_busy;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vectors, handshake corner sequences and randomized traffic against a byte-level memory model
module tb_dmem_lsu;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_unsigned = 0, resp_ready = 1;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m [DEPTH*4];
  typedef struct {logic we; logic [1:0] sz; logic uns; logic [31:0] a, wd, rd; logic er;} vec_t;
  typedef struct {logic [31:0] rd; logic er;} exp_t;
  exp_t q[$];
  vec_t tbl[22];

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic mfault(input logic [1:0] sz, input logic [31:0] a);
    int nb = 1 << sz;
    return sz == 3 || a % nb != 0 || a >= DEPTH * 4;
  endfunction

  function automatic logic [31:0] mload(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int nb = 1 << sz;
    longint v = 0;
    for (int k = 0; k < nb; k++) v += longint'(m[int'(a) + k]) << (8 * k);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  task automatic mstore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) m[int'(a) + k] = 8'(wd >> (8 * k));
  endtask

  task automatic do_reset();
    req_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 1'b0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("clr%0d_busy", i), busy, 1'b1);
      chk($sformatf("clr%0d_ready", i), req_ready, 1'b0);
    end
    @(negedge clk);
    chk("run_busy", busy, 1'b0);
    chk("run_ready", req_ready, 1'b1);
    for (int i = 0; i < DEPTH * 4; i++) m[i] = 0;
    q.delete();
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int t = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    #1;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      #1 t++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 0;
      rd = 'x; er = 'x;
      return;
    end
    @(posedge clk);
    #1 req_valid = 0;
    if (we && !mfault(sz, a)) mstore(sz, a, wd);
    @(negedge clk);
    chk("xact_valid", resp_valid, 1'b1);
    rd = resp_rdata;
    er = resp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic er, acc, cons;
    exp_t e;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h000000AA, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'h1122AA44, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 32'hFFFFFFAA, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h09, 32'h0, 32'h000000AA, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 32'h00001122, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 32'h00001122, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h08, 32'h0, 32'h00000044, 1'b0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h05, 32'h0000FFFF, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'h1122AA44, 1'b0};
    tbl[16] = '{1'b1, 2'd0, 1'b0, 32'h0B, 32'h00000080, 32'h0, 1'b0};
    tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 32'hFFFF8022, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, 32'h00000080, 1'b0};
    tbl[19] = '{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[20] = '{1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000BEEF, 32'h0, 1'b0};
    tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'hBEEF0000, 1'b0};
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, rd, er);
      chk($sformatf("clear_lw%0d_rdata", i), rd, 0);
      chk($sformatf("clear_lw%0d_err", i), er, 1'b0);
    end
    foreach (tbl[i]) begin
      xact(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), er, tbl[i].er);
    end
    // backpressure: hold a load response for three cycles with a second request waiting
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle", resp_valid, 1'b0);
    resp_ready = 0;
    req_valid = 1; req_we = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h8;
    #1 chk("bp_ready0", req_ready, 1'b1);
    @(posedge clk);
    #1 req_size = 0; req_addr = 32'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_rdata", resp_rdata, 32'h8022AA44);
      chk("bp_err", resp_err, 1'b0);
      chk("bp_ready", req_ready, 1'b0);
    end
    resp_ready = 1;
    #1 chk("bp_release_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("bp_next_valid", resp_valid, 1'b1);
    chk("bp_next_rdata", resp_rdata, 32'hFFFFFFAA);
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
    #1 chk("st_ready0", req_ready, 1'b1);
    @(posedge clk);
    mstore(2, 32'h4, 32'hDEADBEEF);
    #1 req_we = 0;
    @(negedge clk);
    chk("st_valid0", resp_valid, 1'b1);
    chk("st_rdata0", resp_rdata, 0);
    chk("st_err0", resp_err, 1'b0);
    chk("st_ready1", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("st_valid1", resp_valid, 1'b1);
    chk("st_rdata1", resp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      chk("rnd_valid", resp_valid, q.size() != 0);
      if (resp_valid && q.size() != 0) begin
        chk("rnd_rdata", resp_rdata, q[0].rd);
        chk("rnd_err", resp_err, q[0].er);
      end
      req_valid = $urandom % 4 != 0;
      req_we = $urandom % 2;
      req_size = $urandom % 8 == 0 ? 2'd3 : 2'($urandom % 3);
      req_unsigned = $urandom % 2;
      req_addr = $urandom % 8 == 0 ? $urandom : $urandom_range(0, DEPTH * 4 - 1);
      req_wdata = $urandom;
      resp_ready = $urandom % 4 != 0;
      #1;
      chk("rnd_ready", req_ready, q.size() == 0 || resp_ready);
      acc = req_valid && req_ready;
      cons = resp_valid && resp_ready;
      @(posedge clk);
      if (cons && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        e.er = mfault(req_size, req_addr);
        e.rd = (req_we || e.er) ? 32'h0 : mload(req_size, req_unsigned, req_addr);
        if (req_we && !e.er) mstore(req_size, req_addr, req_wdata);
        q.push_back(e);
      end
      @(negedge clk);
    end
    req_valid = 0;
    resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid", resp_valid, 1'b0);
    // reset while a store response is still pending
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    resp_ready = 0;
    #1 chk("pend_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("pend_valid", resp_valid, 1'b1);
    do_reset();
    resp_ready = 1;
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("post_rst_lw10", rd, 0);
    xact(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, er);
    chk("post_rst_lw4", rd, 0);
    xact(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, er);
    chk("post_rst_lw8", rd, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end
endmodule
